// File: rtl/ixu_bundle_encoder_if.sv
// ixu_bundle_encoder_if: micro-op in / VLIW bundle out handshake bus between issue producer and bundle encoder
interface ixu_bundle_encoder_if #(parameter int SLOTS = 4);
  logic                uop_valid_i;
  logic                uop_ready_o;
  logic [3:0]          uop_op_i;
  logic                uop_is_imm_i;
  logic [4:0]          uop_rs1_i;
  logic [4:0]          uop_rs2_i;
  logic [4:0]          uop_rd_i;
  logic [11:0]         uop_imm_i;
  logic                flush_i;
  logic                bundle_valid_o;
  logic                bundle_ready_i;
  logic [32*SLOTS-1:0] bundle_o;
  logic [SLOTS-1:0]    bundle_mask_o;
  logic                err_o;
  logic [7:0]          err_count_o;
  modport master (
    output uop_valid_i, uop_op_i, uop_is_imm_i, uop_rs1_i, uop_rs2_i, uop_rd_i, uop_imm_i, flush_i, bundle_ready_i,
    input  uop_ready_o, bundle_valid_o, bundle_o, bundle_mask_o, err_o, err_count_o
  );
  modport slave (
    input  uop_valid_i, uop_op_i, uop_is_imm_i, uop_rs1_i, uop_rs2_i, uop_rd_i, uop_imm_i, flush_i, bundle_ready_i,
    output uop_ready_o, bundle_valid_o, bundle_o, bundle_mask_o, err_o, err_count_o
  );
endinterface

// File: rtl/ixu_bundle_encoder.sv
// ixu_bundle_encoder: encodes IXU uops into RV32 R/I ALU words packed SLOTS per bundle; IXU_ENC_TIMEOUT_EN enables idle auto-flush
module ixu_bundle_encoder #(
  parameter int SLOTS   = 4,
  parameter int TIMEOUT = 16
) (
  input logic clk,
  input logic rst,
  ixu_bundle_encoder_if.slave bus
);
  localparam int IW = $clog2(SLOTS);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] FULL = CW'(SLOTS);
  typedef enum logic {FILL, HOLD} state_t;
  state_t              state;
  logic [CW-1:0]       count;
  logic [32*SLOTS-1:0] bundle;
  logic [SLOTS-1:0]    mask;
  logic                err;
  logic [7:0]          err_count;
  logic                illegal, fire, acc, shift, go_hold, tmo;
  logic [2:0]          f3;
  logic [6:0]          f7;
  logic [31:0]         word;
  logic [CW-1:0]       nxt;
  logic [IW-1:0]       idx;
  assign illegal = bus.uop_op_i > 4'd9 || (bus.uop_op_i == 4'd1 && bus.uop_is_imm_i);
  assign fire    = bus.uop_valid_i && state == FILL;
  assign acc     = fire && !illegal;
  assign nxt     = count + CW'(acc);
  assign idx     = count[IW-1:0];
  assign shift   = bus.uop_op_i == 4'd5 || bus.uop_op_i == 4'd6 || bus.uop_op_i == 4'd7;
  assign f7      = (bus.uop_op_i == 4'd1 || bus.uop_op_i == 4'd7) ? 7'h20 : 7'h00;
  assign go_hold = (acc && nxt == FULL) || ((bus.flush_i || tmo) && nxt != '0);
  always_comb begin
    f3 = 3'd0;
    case (bus.uop_op_i)
      4'd2:       f3 = 3'd4;
      4'd3:       f3 = 3'd6;
      4'd4:       f3 = 3'd7;
      4'd5:       f3 = 3'd1;
      4'd6, 4'd7: f3 = 3'd5;
      4'd8:       f3 = 3'd2;
      4'd9:       f3 = 3'd3;
      default:    f3 = 3'd0;
    endcase
  end
  assign word = bus.uop_is_imm_i
    ? {shift ? {f7, bus.uop_imm_i[4:0]} : bus.uop_imm_i, bus.uop_rs1_i, f3, bus.uop_rd_i, 7'b0010011}
    : {f7, bus.uop_rs2_i, bus.uop_rs1_i, f3, bus.uop_rd_i, 7'b0110011};
`ifdef IXU_ENC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle;
  assign tmo = idle == TW'(TIMEOUT);
  always_ff @(posedge clk)
    if (rst || state != FILL || acc || go_hold) idle <= '0;
    else if (count != '0) idle <= idle + TW'(1);
`else
  assign tmo = 1'b0 && TIMEOUT > 0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      count     <= '0;
      bundle    <= '0;
      mask      <= '0;
      err       <= 1'b0;
      err_count <= 8'd0;
    end else begin
      err <= fire && illegal;
      if (fire && illegal && err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (state == FILL) begin
        if (acc) begin
          bundle[32*idx +: 32] <= word;
          mask[idx]            <= 1'b1;
          count                <= nxt;
        end
        if (go_hold) state <= HOLD;
      end else if (bus.bundle_ready_i) begin
        state  <= FILL;
        count  <= '0;
        bundle <= '0;
        mask   <= '0;
      end
    end
  end
  assign bus.uop_ready_o    = state == FILL;
  assign bus.bundle_valid_o = state == HOLD;
  assign bus.bundle_o       = bundle;
  assign bus.bundle_mask_o  = mask;
  assign bus.err_o          = err;
  assign bus.err_count_o    = err_count;
endmodule

// File: tb/tb_ixu_bundle_encoder.sv
// tb_ixu_bundle_encoder: directed self-checking bench for ixu_bundle_encoder
module tb_ixu_bundle_encoder;
  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  ixu_bundle_encoder_if #(.SLOTS(4)) bus();
  ixu_bundle_encoder #(.SLOTS(4), .TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic set_uop(input logic [3:0] op, input logic im, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [11:0] imm);
    bus.uop_valid_i  = 1'b1;
    bus.uop_op_i     = op;
    bus.uop_is_imm_i = im;
    bus.uop_rs1_i    = rs1;
    bus.uop_rs2_i    = rs2;
    bus.uop_rd_i     = rd;
    bus.uop_imm_i    = imm;
  endtask
  task automatic idle_in;
    set_uop(4'd0, 1'b0, 5'd0, 5'd0, 5'd0, 12'd0);
    bus.uop_valid_i    = 1'b0;
    bus.flush_i        = 1'b0;
    bus.bundle_ready_i = 1'b0;
  endtask
  task automatic fill_first_four;
    @(negedge clk); set_uop(4'd0, 1'b0, 5'd1, 5'd2, 5'd3, 12'd0);
    @(negedge clk); set_uop(4'd1, 1'b0, 5'd6, 5'd7, 5'd5, 12'd0);
    @(negedge clk); set_uop(4'd0, 1'b1, 5'd0, 5'd0, 5'd1, 12'd5);
    @(negedge clk); set_uop(4'd7, 1'b1, 5'd2, 5'd0, 5'd2, 12'd3);
  endtask
  task automatic release_bundle;
    bus.bundle_ready_i = 1'b1;
    @(negedge clk);
    bus.bundle_ready_i = 1'b0;
    checks++; if (bus.bundle_valid_o !== 1'b0) begin errors++; $display("FAIL release_valid: got %b want 0", bus.bundle_valid_o); end
    checks++; if (bus.bundle_mask_o !== 4'b0000) begin errors++; $display("FAIL release_mask: got %b want 0000", bus.bundle_mask_o); end
    checks++; if (bus.bundle_o !== 128'h0) begin errors++; $display("FAIL release_bundle: got %h want 0", bus.bundle_o); end
    checks++; if (bus.uop_ready_o !== 1'b1) begin errors++; $display("FAIL release_ready: got %b want 1", bus.uop_ready_o); end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    idle_in;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.bundle_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.bundle_valid_o); end
    checks++; if (bus.uop_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.uop_ready_o); end
    checks++; if (bus.bundle_o !== 128'h0) begin errors++; $display("FAIL reset_bundle: got %h want 0", bus.bundle_o); end
    checks++; if (bus.bundle_mask_o !== 4'b0000) begin errors++; $display("FAIL reset_mask: got %b want 0000", bus.bundle_mask_o); end
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.err_o); end
    checks++; if (bus.err_count_o !== 8'd0) begin errors++; $display("FAIL reset_err_count: got %0d want 0", bus.err_count_o); end
  endtask
  task automatic test_back_to_back;
    fill_first_four;
    checks++; if (bus.bundle_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_early_valid: got %b want 0", bus.bundle_valid_o); end
    @(negedge clk); idle_in;
    checks++; if (bus.bundle_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", bus.bundle_valid_o); end
    checks++; if (bus.uop_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_ready: got %b want 0", bus.uop_ready_o); end
    checks++; if (bus.bundle_o !== 128'h40315113_00500093_407302B3_002081B3) begin errors++; $display("FAIL b2b_bundle: got %h want 40315113_00500093_407302b3_002081b3", bus.bundle_o); end
    checks++; if (bus.bundle_mask_o !== 4'b1111) begin errors++; $display("FAIL b2b_mask: got %b want 1111", bus.bundle_mask_o); end
    release_bundle;
  endtask
  task automatic test_encoding;
    @(negedge clk); set_uop(4'd2, 1'b0, 5'd5, 5'd6, 5'd4, 12'd0);
    @(negedge clk); set_uop(4'd8, 1'b1, 5'd8, 5'd0, 5'd7, 12'hFFF);
    @(negedge clk); set_uop(4'd5, 1'b1, 5'd10, 5'd0, 5'd9, 12'hFE3);
    @(negedge clk); set_uop(4'd6, 1'b0, 5'd12, 5'd13, 5'd11, 12'd0);
    @(negedge clk); idle_in;
    checks++; if (bus.bundle_o !== 128'h00D655B3_00351493_FFF42393_0062C233) begin errors++; $display("FAIL enc_bundle: got %h want 00d655b3_00351493_fff42393_0062c233", bus.bundle_o); end
    checks++; if (bus.bundle_mask_o !== 4'b1111) begin errors++; $display("FAIL enc_mask: got %b want 1111", bus.bundle_mask_o); end
    release_bundle;
  endtask
  task automatic test_flush;
    @(negedge clk); bus.flush_i = 1'b1;
    @(negedge clk); bus.flush_i = 1'b0;
    checks++; if (bus.bundle_valid_o !== 1'b0) begin errors++; $display("FAIL flush_empty_valid: got %b want 0", bus.bundle_valid_o); end
    set_uop(4'd0, 1'b0, 5'd1, 5'd2, 5'd3, 12'd0);
    @(negedge clk); set_uop(4'd0, 1'b1, 5'd0, 5'd0, 5'd1, 12'd5);
    @(negedge clk); bus.uop_valid_i = 1'b0; bus.flush_i = 1'b1;
    checks++; if (bus.bundle_valid_o !== 1'b0) begin errors++; $display("FAIL flush_pre_valid: got %b want 0", bus.bundle_valid_o); end
    @(negedge clk);
    checks++; if (bus.bundle_valid_o !== 1'b1) begin errors++; $display("FAIL flush_valid: got %b want 1", bus.bundle_valid_o); end
    checks++; if (bus.bundle_o !== 128'h00000000_00000000_00500093_002081B3) begin errors++; $display("FAIL flush_bundle: got %h want 0_0_00500093_002081b3", bus.bundle_o); end
    checks++; if (bus.bundle_mask_o !== 4'b0011) begin errors++; $display("FAIL flush_mask: got %b want 0011", bus.bundle_mask_o); end
    @(negedge clk); bus.flush_i = 1'b0;
    checks++; if (bus.bundle_mask_o !== 4'b0011) begin errors++; $display("FAIL flush_hold_mask: got %b want 0011", bus.bundle_mask_o); end
    release_bundle;
  endtask
  task automatic test_stall;
    fill_first_four;
    @(negedge clk); set_uop(4'd0, 1'b0, 5'd1, 5'd2, 5'd3, 12'd0); bus.flush_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (bus.uop_ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d]: got %b want 0", i, bus.uop_ready_o); end
      checks++; if (bus.bundle_valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", i, bus.bundle_valid_o); end
      checks++; if (bus.bundle_o !== 128'h40315113_00500093_407302B3_002081B3) begin errors++; $display("FAIL stall_bundle[%0d]: got %h", i, bus.bundle_o); end
      checks++; if (bus.bundle_mask_o !== 4'b1111) begin errors++; $display("FAIL stall_mask[%0d]: got %b want 1111", i, bus.bundle_mask_o); end
    end
    idle_in;
    release_bundle;
  endtask
  task automatic test_illegal;
    @(negedge clk); set_uop(4'hA, 1'b0, 5'd1, 5'd2, 5'd3, 12'd0);
    @(negedge clk); set_uop(4'd1, 1'b1, 5'd1, 5'd0, 5'd3, 12'd7);
    checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL ill_err1: got %b want 1", bus.err_o); end
    checks++; if (bus.err_count_o !== 8'd1) begin errors++; $display("FAIL ill_cnt1: got %0d want 1", bus.err_count_o); end
    @(negedge clk); idle_in;
    checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL ill_err2: got %b want 1", bus.err_o); end
    checks++; if (bus.err_count_o !== 8'd2) begin errors++; $display("FAIL ill_cnt2: got %0d want 2", bus.err_count_o); end
    checks++; if (bus.bundle_mask_o !== 4'b0000) begin errors++; $display("FAIL ill_mask: got %b want 0000", bus.bundle_mask_o); end
    @(negedge clk);
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL ill_err_pulse: got %b want 0", bus.err_o); end
    set_uop(4'hF, 1'b0, 5'd1, 5'd2, 5'd3, 12'd0); bus.flush_i = 1'b1;
    @(negedge clk); idle_in;
    checks++; if (bus.bundle_valid_o !== 1'b0) begin errors++; $display("FAIL ill_flush_empty: got %b want 0", bus.bundle_valid_o); end
    set_uop(4'd0, 1'b0, 5'd1, 5'd2, 5'd3, 12'd0);
    @(negedge clk); set_uop(4'hA, 1'b0, 5'd1, 5'd2, 5'd3, 12'd0); bus.flush_i = 1'b1;
    @(negedge clk); idle_in;
    checks++; if (bus.bundle_valid_o !== 1'b1) begin errors++; $display("FAIL ill_flush_valid: got %b want 1", bus.bundle_valid_o); end
    checks++; if (bus.bundle_o !== 128'h00000000_00000000_00000000_002081B3) begin errors++; $display("FAIL ill_flush_bundle: got %h want 0_0_0_002081b3", bus.bundle_o); end
    checks++; if (bus.bundle_mask_o !== 4'b0001) begin errors++; $display("FAIL ill_flush_mask: got %b want 0001", bus.bundle_mask_o); end
    checks++; if (bus.err_count_o !== 8'd4) begin errors++; $display("FAIL ill_cnt4: got %0d want 4", bus.err_count_o); end
    release_bundle;
    set_uop(4'hF, 1'b0, 5'd1, 5'd2, 5'd3, 12'd0);
    repeat (256) @(negedge clk);
    idle_in;
    @(negedge clk);
    checks++; if (bus.err_count_o !== 8'd255) begin errors++; $display("FAIL ill_saturate: got %0d want 255", bus.err_count_o); end
    checks++; if (bus.bundle_mask_o !== 4'b0000) begin errors++; $display("FAIL ill_sat_mask: got %b want 0000", bus.bundle_mask_o); end
  endtask
  task automatic test_reset_mid;
    @(negedge clk); set_uop(4'd0, 1'b0, 5'd1, 5'd2, 5'd3, 12'd0);
    @(negedge clk); set_uop(4'd1, 1'b0, 5'd6, 5'd7, 5'd5, 12'd0);
    @(negedge clk); set_uop(4'd0, 1'b1, 5'd0, 5'd0, 5'd1, 12'd5);
    @(negedge clk); idle_in; rst = 1'b1;
    checks++; if (bus.bundle_mask_o !== 4'b0111) begin errors++; $display("FAIL rmid_pre_mask: got %b want 0111", bus.bundle_mask_o); end
    @(negedge clk); rst = 1'b0;
    checks++; if (bus.bundle_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", bus.bundle_valid_o); end
    checks++; if (bus.bundle_mask_o !== 4'b0000) begin errors++; $display("FAIL rmid_mask: got %b want 0000", bus.bundle_mask_o); end
    checks++; if (bus.bundle_o !== 128'h0) begin errors++; $display("FAIL rmid_bundle: got %h want 0", bus.bundle_o); end
    checks++; if (bus.err_count_o !== 8'd0) begin errors++; $display("FAIL rmid_err_count: got %0d want 0", bus.err_count_o); end
    @(negedge clk);
    checks++; if (bus.bundle_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_after_valid: got %b want 0", bus.bundle_valid_o); end
  endtask
  task automatic test_timeout;
    int first;
    first = -1;
    @(negedge clk); set_uop(4'd0, 1'b0, 5'd1, 5'd2, 5'd3, 12'd0);
    @(negedge clk); idle_in;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (bus.bundle_valid_o === 1'b1 && first < 0) first = i;
    end
    checks++; if (bus.bundle_mask_o !== 4'b0001) begin errors++; $display("FAIL tmo_mask: got %b want 0001", bus.bundle_mask_o); end
`ifdef IXU_ENC_TIMEOUT_EN
    checks++; if (first < 16 || first > 18) begin errors++; $display("FAIL tmo_flush_cycle: got %0d want 16..18", first); end
`else
    checks++; if (first !== -1) begin errors++; $display("FAIL tmo_no_flush: got valid at %0d want never", first); end
    bus.flush_i = 1'b1;
    @(negedge clk); bus.flush_i = 1'b0;
`endif
    release_bundle;
  endtask
  initial begin
    test_reset;
    test_back_to_back;
    test_encoding;
    test_flush;
    test_stall;
    test_illegal;
    test_reset_mid;
    test_timeout;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
